// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// The work register shifts right one bit per clock, and each BCD digit is corrected per iteration.

module bcd_dig_fix (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  // A digit >= 8 cannot underflow here, because 8-3 = 5.
  assign d_o = (d_i >= 4'd8) ? d_i - 4'd3 : d_i;
endmodule

module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   bcd_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [BIN_W-1:0]      bin_out_o,
  output logic                  err_o
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int WRK_W = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WRK_W-1:0]  work_q, work_d, work_sh, work_fix;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DIGITS-1:0] bad;

  assign work_sh = work_q >> 1;
  assign work_fix[BIN_W-1:0] = work_sh[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_dig_fix u_fix (
      .d_i (work_sh[BIN_W+4*g +: 4]),
      .d_o (work_fix[BIN_W+4*g +: 4])
    );
    assign bad[g] = (bcd_in_i[4*g +: 4] > 4'd9);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (|bad) begin
            // A rejected operand completes immediately, and no iterations run.
            err_d  = 1'b1;
            bin_d  = '0;
            done_d = 1'b1;
          end else begin
            work_d  = {bcd_in_i, {BIN_W{1'b0}}};
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        work_d = work_fix;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bin_d   = work_fix[BIN_W-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      bin_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      bin_q   <= bin_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o    = (state_q == CONV);
  assign done_o    = done_q;
  assign bin_out_o = bin_q;
  assign err_o     = err_q;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq (DIGITS=3, BIN_W=10). Outputs are compared against a decimal-arithmetic model.

module tb_bcd_to_binary_seq;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [11:0]       bcd_in = '0;
  logic              busy, done, err;
  logic [BIN_W-1:0]  bin_out;

  int tests = 0;
  int fails = 0;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (start),
    .bcd_in_i  (bcd_in),
    .busy_o    (busy),
    .done_o    (done),
    .bin_out_o (bin_out),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  // Reference model: the digit-weighted decimal value, plus a check that every digit is valid.
  function automatic int ref_val(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit ref_bad(input logic [11:0] b);
    return (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance negedges until done is seen or the bound expires. n is the number of edges after the current sample.
  task automatic wait_done(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'(n), 32'd10);
  endtask

  // Issue a start pulse and check the complete result against the model.
  task automatic convert(input logic [11:0] b, input string tag);
    int n;
    @(negedge clk);
    start = 1'b1; bcd_in = b;
    @(negedge clk);
    start = 1'b0; bcd_in = $urandom;
    if (ref_bad(b)) begin
      chk({tag, "_bad_done"}, 32'(done), 32'd1);
      chk({tag, "_bad_err"},  32'(err),  32'd1);
      chk({tag, "_bad_bin"},  32'(bin_out), 32'd0);
      chk({tag, "_bad_busy"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({tag, "_bad_busy2"}, 32'(busy), 32'd0);
      chk({tag, "_bad_drop"},  32'(done), 32'd0);
    end else begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_err_clr"}, 32'(err), 32'd0);
      wait_done(n);
      chk({tag, "_lat"}, 32'(n), 32'd10);
      chk({tag, "_bin"}, 32'(bin_out), 32'(ref_val(b)));
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int n;
    logic [11:0] r;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_bin",  32'(bin_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // The maximum value is 999; busy must stay high for exactly 10 cycles
    @(negedge clk);
    start = 1'b1; bcd_in = 12'h999;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("h999_busy", 32'(busy), 32'd1);
      chk("h999_nodone", 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("h999_done", 32'(done), 32'd1);
    chk("h999_bin", 32'(bin_out), 32'd999);
    chk("h999_err", 32'(err), 32'd0);
    chk("h999_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("h999_done_drop", 32'(done), 32'd0);
    chk("h999_hold", 32'(bin_out), 32'd999);

    // Invalid operand, followed by a valid one that clears err
    convert(12'h1A5, "h1A5");
    chk("h1A5_err_hold", 32'(err), 32'd1);
    convert(12'h042, "h042");

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; bcd_in = 12'h409;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; bcd_in = 12'h123;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("ign_lat", 32'(n), 32'd5);
    chk("ign_bin", 32'(bin_out), 32'd409);
    @(negedge clk);
    chk("ign_idle", 32'(busy), 32'd0);

    // Holding start high gives back-to-back conversions with no idle gap
    start = 1'b1; bcd_in = 12'h000;
    @(negedge clk);
    wait_done(n);
    chk("b2b0_lat", 32'(n), 32'd10);
    chk("b2b0_bin", 32'(bin_out), 32'd0);
    bcd_in = 12'h001;
    @(negedge clk);
    chk("b2b1_acc", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(n);
    chk("b2b1_lat", 32'(n), 32'd10);
    chk("b2b1_bin", 32'(bin_out), 32'd1);

    // Reset mid-conversion
    @(negedge clk);
    start = 1'b1; bcd_in = 12'h750;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_err",  32'(err),  32'd0);
    chk("rst_mid_bin",  32'(bin_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("rst_mid_quiet", 32'(n), 32'd0);
    convert(12'h750, "h750");

    // Full sweep of the valid codes, visited in a randomly rotated order
    n = $urandom_range(999, 0);
    for (int v = 0; v < 1000; v++) convert(to_bcd((v + n) % 1000), "sweep");

    // Random codes, including invalid digits
    for (int k = 0; k < 60; k++) begin
      r = 12'($urandom);
      convert(r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_to_binary_seq.md
# bcd_to_binary_seq

Sequential BCD-to-binary converter: the inverse of the combinational binary-to-BCD block. It accepts a packed multi-digit BCD word and produces the equivalent unsigned binary value using reverse double-dabble, one bit per clock. A start/busy/done handshake lets it sit between a BCD keypad or display-register path and binary arithmetic logic.

## Interface
- DIGITS, 3: number of packed BCD digits; digit 0 is bits [3:0].
- BIN_W, 10: output width. Must be at least ceil(log2(10^DIGITS)); 10 covers 3 digits.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- start  input  1  request a conversion; sampled only while idle.
- bcd_in  input  4*DIGITS  BCD operand; sampled on the same edge as start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin_out/err are updated.
- bin_out  output  BIN_W  converted value; holds until the next completion.
- err  output  1  the last accepted start carried a digit > 9.

## Operation
- State machine has two states:
  - IDLE: busy=0.
  - CONV: busy=1. A bit counter runs 0..BIN_W-1.
- Datapath:
  - The work register is {bcd_sh[4*DIGITS-1:0], bin_sh[BIN_W-1:0]}.
  - bcd_sh is loaded from bcd_in; bin_sh is loaded with 0.
- Accepting start in IDLE when all digits are ≤ 9:
  - Load the work register.
  - Clear err.
  - Enter CONV.
- Accepting start in IDLE when any digit is > 9:
  - No conversion runs; stay in IDLE.
  - err<=1, bin_out<=0, done<=1 on the same edge.
- Each edge in CONV performs one iteration:
  - First, shift the whole work register right by 1. The bcd_sh LSB enters the bin_sh MSB; 0 enters the bcd_sh MSB.
  - Then, in every digit of bcd_sh, if the digit is ≥ 8, subtract 3.
  - This is a single combinational step per iteration (shift then correct), registered once.
- On the edge performing iteration BIN_W:
  - bin_out <= final bin_sh.
  - done <= 1.
  - Return to IDLE.
- Arithmetic rules:
  - Digit correction is 4-bit and cannot underflow, since it only applies when the digit is ≥ 8.
  - If BIN_W is too small, only the low BIN_W bits of the true value are produced; this is a parameter error, not detected at runtime.
- start while busy=1 is ignored. bcd_in is don't-care outside the accept edge.
- start asserted in the cycle where done=1 (state is IDLE) is accepted: back-to-back conversions are allowed.
- err stays stable until the next accepted start.

## Timing
- Reset values (asynchronous, rst_n=0):
  - State IDLE, counter 0, busy=0, done=0, err=0, bin_out=0, work register 0.
- Reset mid-conversion aborts immediately. No done pulse follows, and bin_out returns to 0.
- Start handshake: start is sampled at edge E0, and busy is high from after E0.
- Valid conversion:
  - Edges E1..E(BIN_W) perform the iterations.
  - After E(BIN_W): busy=0, done=1, bin_out valid. This is a latency of BIN_W+1 edges including the accept edge; 11 cycles for BIN_W=10.
  - done drops after E(BIN_W+1).
- Invalid operand: after E0, done=1, err=1, bin_out=0, and busy never asserts.
- Throughput: one conversion per BIN_W+1 cycles when start is held continuously high.

## Test plan
- The bench uses DIGITS=3, BIN_W=10 for every scenario.
- bcd_in=12'h999, start pulse → busy for 10 cycles, then done pulse with bin_out=10'd999 (11_1110_0111) and err=0.
- Sweep all 1000 valid codes 000..999 → bin_out equals the decimal value each time. done arrives exactly 10 edges after the accept edge.
- bcd_in=12'h1A5, start → one cycle later done=1, err=1, bin_out=0, busy stays 0. A following start with 12'h042 → err clears at accept; bin_out=42 after the conversion.
- Start conversion of 12'h409, then pulse start with 12'h123 at iteration 4 → the second start is ignored; bin_out=409.
- start held high continuously with 12'h000 then 12'h001 → bin_out=0 then 1. The second conversion is accepted in the done cycle with no idle gap.
- rst_n low at iteration 5 of 12'h750 → busy, done, err and bin_out are 0 immediately with no later done. After release, a new start of 12'h750 yields 750.
